// File: rtl/bit_sync_filt.sv
// Multi-channel bit synchroniser with per-channel stability filter and
// registered edge detection. Each bit of the bus is an independent channel;
// the bus is never treated as a coherent word.
module bit_sync_filt #(
    parameter int unsigned          BUS_WIDTH   = 1,
    parameter int unsigned          NUM_STAGES  = 2,
    parameter int unsigned          FILT_CYCLES = 4,
    parameter logic [BUS_WIDTH-1:0] RST_VAL     = {BUS_WIDTH{1'b0}}
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [BUS_WIDTH-1:0] async,
    output logic [BUS_WIDTH-1:0] sync,
    output logic [BUS_WIDTH-1:0] rise,
    output logic [BUS_WIDTH-1:0] fall,
    output logic                 any_edge
);

    localparam int unsigned CNT_W = (FILT_CYCLES > 1) ? $clog2(FILT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILT_CYCLES - 1);

    if (NUM_STAGES < 2) begin : g_bad_stages
        $error("bit_sync_filt: NUM_STAGES must be 2 or more");
    end
    if (FILT_CYCLES < 1) begin : g_bad_filt
        $error("bit_sync_filt: FILT_CYCLES must be 1 or more");
    end

    logic [BUS_WIDTH-1:0] stage_q [NUM_STAGES];
    logic [BUS_WIDTH-1:0] raw;

    logic [CNT_W-1:0]     cnt_q [BUS_WIDTH];
    logic [CNT_W-1:0]     cnt_d [BUS_WIDTH];
    logic [BUS_WIDTH-1:0] sync_q, sync_d;
    logic [BUS_WIDTH-1:0] rise_q, rise_d;
    logic [BUS_WIDTH-1:0] fall_q, fall_d;

    // Plain shift chain with no logic between stages; shifts regardless of en.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned k = 0; k < NUM_STAGES; k++) begin
                stage_q[k] <= RST_VAL;
            end
        end else begin
            stage_q[0] <= async;
            for (int unsigned k = 1; k < NUM_STAGES; k++) begin
                stage_q[k] <= stage_q[k-1];
            end
        end
    end

    assign raw = stage_q[NUM_STAGES-1];

    // Filter next-state: a level is accepted only after FILT_CYCLES
    // consecutive differing samples; any matching sample clears the count.
    always_comb begin
        sync_d = sync_q;
        rise_d = '0;
        fall_d = '0;
        for (int unsigned i = 0; i < BUS_WIDTH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (en) begin
                if (raw[i] == sync_q[i]) begin
                    cnt_d[i] = '0;
                end else if (cnt_q[i] == CNT_LAST) begin
                    sync_d[i] = raw[i];
                    cnt_d[i]  = '0;
                    rise_d[i] = raw[i];
                    fall_d[i] = ~raw[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    // Filter state and registered edge pulses; reset discards any count.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= RST_VAL;
            rise_q <= '0;
            fall_q <= '0;
            for (int unsigned i = 0; i < BUS_WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync_q <= sync_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
            for (int unsigned i = 0; i < BUS_WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign sync     = sync_q;
    assign rise     = rise_q;
    assign fall     = fall_q;
    assign any_edge = |(rise_q | fall_q);

endmodule

// File: tb/tb_bit_sync_filt.sv
// Directed bench for bit_sync_filt: a 4-channel instance with RST_VAL=0 and a
// 1-channel instance with RST_VAL=1, both with NUM_STAGES=2, FILT_CYCLES=4.
module tb_bit_sync_filt;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rst1 = 1'b1;
    logic       en = 1'b1;
    logic [3:0] async = 4'b0000;
    logic [3:0] sync, rise, fall;
    logic       any_edge;
    logic [0:0] async1 = 1'b0;
    logic [0:0] sync1, rise1, fall1;
    logic       any1;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    bit_sync_filt #(
        .BUS_WIDTH(4)
    ) dut0 (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .async    (async),
        .sync     (sync),
        .rise     (rise),
        .fall     (fall),
        .any_edge (any_edge)
    );

    bit_sync_filt #(
        .BUS_WIDTH(1),
        .RST_VAL  (1'b1)
    ) dut1 (
        .clk      (clk),
        .rst      (rst1),
        .en       (en),
        .async    (async1),
        .sync     (sync1),
        .rise     (rise1),
        .fall     (fall1),
        .any_edge (any1)
    );

    // Advance past one rising edge; outputs are sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        async = 4'b0000;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if ({sync, rise, fall, any_edge} !== 13'b0) begin
                n_errors++;
                $display("FAIL reset_hold cyc%0d: got sync=%b rise=%b fall=%b any=%b, want all 0",
                         i, sync, rise, fall, any_edge);
            end
        end
        n_checks++;
        if (sync1 !== 1'b1 || fall1 !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_rstval: got sync1=%b fall1=%b, want 1 0", sync1, fall1);
        end
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            n_checks++;
            if ({sync, rise, fall, any_edge} !== 13'b0) begin
                n_errors++;
                $display("FAIL steady cyc%0d: got sync=%b rise=%b fall=%b any=%b, want all 0",
                         i, sync, rise, fall, any_edge);
            end
        end
    endtask

    task automatic test_latency();
        async = 4'b0001;
        tick();  // capture edge k
        for (int i = 1; i <= 4; i++) begin
            tick();
            n_checks++;
            if (sync !== 4'b0000 || rise !== 4'b0000) begin
                n_errors++;
                $display("FAIL rise_early k+%0d: got sync=%b rise=%b, want 0000 0000", i, sync, rise);
            end
        end
        tick();  // k+5
        n_checks++;
        if (sync !== 4'b0001 || rise !== 4'b0001 || fall !== 4'b0000 || any_edge !== 1'b1) begin
            n_errors++;
            $display("FAIL rise_latency: got sync=%b rise=%b fall=%b any=%b, want 0001 0001 0000 1",
                     sync, rise, fall, any_edge);
        end
        tick();
        n_checks++;
        if (sync !== 4'b0001 || rise !== 4'b0000 || any_edge !== 1'b0) begin
            n_errors++;
            $display("FAIL rise_one_cycle: got sync=%b rise=%b any=%b, want 0001 0000 0",
                     sync, rise, any_edge);
        end
        for (int i = 0; i < 5; i++) tick();
        async = 4'b0000;
        tick();
        for (int i = 1; i <= 4; i++) begin
            tick();
            n_checks++;
            if (sync !== 4'b0001 || fall !== 4'b0000) begin
                n_errors++;
                $display("FAIL fall_early k+%0d: got sync=%b fall=%b, want 0001 0000", i, sync, fall);
            end
        end
        tick();
        n_checks++;
        if (sync !== 4'b0000 || fall !== 4'b0001 || rise !== 4'b0000) begin
            n_errors++;
            $display("FAIL fall_latency: got sync=%b fall=%b rise=%b, want 0000 0001 0000",
                     sync, fall, rise);
        end
        tick();
        n_checks++;
        if (fall !== 4'b0000) begin
            n_errors++;
            $display("FAIL fall_one_cycle: got fall=%b, want 0000", fall);
        end
    endtask

    task automatic test_glitch();
        int n_rise;
        int n_fall;
        bit seen_high;
        for (int i = 0; i < 4; i++) tick();
        async = 4'b0001;
        for (int i = 0; i < 3; i++) tick();
        async = 4'b0000;
        for (int i = 0; i < 12; i++) begin
            tick();
            n_checks++;
            if (sync !== 4'b0000 || rise !== 4'b0000) begin
                n_errors++;
                $display("FAIL glitch3 cyc%0d: got sync=%b rise=%b, want 0000 0000", i, sync, rise);
            end
        end
        n_rise = 0;
        n_fall = 0;
        seen_high = 1'b0;
        async = 4'b0001;
        for (int i = 0; i < 4; i++) tick();
        async = 4'b0000;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (rise[0]) n_rise++;
            if (fall[0]) n_fall++;
            if (sync[0]) seen_high = 1'b1;
        end
        n_checks++;
        if (n_rise != 1 || n_fall != 1 || seen_high !== 1'b1 || sync !== 4'b0000) begin
            n_errors++;
            $display("FAIL pulse4: got rises=%0d falls=%0d high=%b sync=%b, want 1 1 1 0000",
                     n_rise, n_fall, seen_high, sync);
        end
    endtask

    task automatic test_multi();
        async = 4'b0101;
        tick();
        for (int i = 1; i <= 4; i++) begin
            tick();
            n_checks++;
            if (rise !== 4'b0000 || any_edge !== 1'b0) begin
                n_errors++;
                $display("FAIL multi_early k+%0d: got rise=%b any=%b, want 0000 0", i, rise, any_edge);
            end
        end
        tick();
        n_checks++;
        if (rise !== 4'b0101 || fall !== 4'b0000 || sync !== 4'b0101 || any_edge !== 1'b1) begin
            n_errors++;
            $display("FAIL multi_rise: got rise=%b fall=%b sync=%b any=%b, want 0101 0000 0101 1",
                     rise, fall, sync, any_edge);
        end
        tick();
        n_checks++;
        if (any_edge !== 1'b0 || rise !== 4'b0000) begin
            n_errors++;
            $display("FAIL multi_any_one: got any=%b rise=%b, want 0 0000", any_edge, rise);
        end
        async = 4'b0110;
        tick();
        for (int i = 1; i <= 4; i++) tick();
        tick();
        n_checks++;
        if (rise !== 4'b0010 || fall !== 4'b0001 || sync !== 4'b0110 || any_edge !== 1'b1) begin
            n_errors++;
            $display("FAIL multi_mixed: got rise=%b fall=%b sync=%b any=%b, want 0010 0001 0110 1",
                     rise, fall, sync, any_edge);
        end
        tick();
        n_checks++;
        if (any_edge !== 1'b0) begin
            n_errors++;
            $display("FAIL multi_mixed_one: got any=%b, want 0", any_edge);
        end
    endtask

    task automatic test_enable();
        async = 4'b0111;
        tick();  // k: capture
        tick();  // k+1: raw changes
        tick();  // k+2: count 1
        tick();  // k+3: count 2
        en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            n_checks++;
            if (rise !== 4'b0000 || fall !== 4'b0000 || sync !== 4'b0110) begin
                n_errors++;
                $display("FAIL en_hold cyc%0d: got sync=%b rise=%b fall=%b, want 0110 0000 0000",
                         i, sync, rise, fall);
            end
        end
        en = 1'b1;
        tick();
        n_checks++;
        if (sync !== 4'b0110 || rise !== 4'b0000) begin
            n_errors++;
            $display("FAIL en_resume1: got sync=%b rise=%b, want 0110 0000", sync, rise);
        end
        tick();
        n_checks++;
        if (sync !== 4'b0111 || rise !== 4'b0001) begin
            n_errors++;
            $display("FAIL en_resume2: got sync=%b rise=%b, want 0111 0001", sync, rise);
        end
        tick();
    endtask

    task automatic test_reset_midcount();
        async = 4'b1111;
        for (int i = 0; i < 5; i++) tick();  // channel 3 count now 3 of 4
        rst = 1'b1;
        async = 4'b0000;
        tick();
        n_checks++;
        if (sync !== 4'b0000 || rise !== 4'b0000 || fall !== 4'b0000 || any_edge !== 1'b0) begin
            n_errors++;
            $display("FAIL rst_mid: got sync=%b rise=%b fall=%b any=%b, want 0000 0000 0000 0",
                     sync, rise, fall, any_edge);
        end
        tick();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            n_checks++;
            if ({sync, rise, fall, any_edge} !== 13'b0) begin
                n_errors++;
                $display("FAIL rst_mid_after cyc%0d: got sync=%b rise=%b fall=%b any=%b, want all 0",
                         i, sync, rise, fall, any_edge);
            end
        end
    endtask

    task automatic test_rst_val();
        async1 = 1'b0;
        rst1 = 1'b0;
        tick();  // first edge with reset low captures 0
        for (int i = 1; i <= 4; i++) begin
            tick();
            n_checks++;
            if (sync1 !== 1'b1 || fall1 !== 1'b0) begin
                n_errors++;
                $display("FAIL rstval_early k+%0d: got sync1=%b fall1=%b, want 1 0", i, sync1, fall1);
            end
        end
        tick();
        n_checks++;
        if (sync1 !== 1'b0 || fall1 !== 1'b1 || rise1 !== 1'b0 || any1 !== 1'b1) begin
            n_errors++;
            $display("FAIL rstval_fall: got sync1=%b fall1=%b rise1=%b any1=%b, want 0 1 0 1",
                     sync1, fall1, rise1, any1);
        end
        for (int i = 0; i < 10; i++) begin
            tick();
            n_checks++;
            if (sync1 !== 1'b0 || fall1 !== 1'b0 || rise1 !== 1'b0) begin
                n_errors++;
                $display("FAIL rstval_after cyc%0d: got sync1=%b fall1=%b rise1=%b, want 0 0 0",
                         i, sync1, fall1, rise1);
            end
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_glitch();
        test_multi();
        test_enable();
        test_reset_midcount();
        test_rst_val();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
